seven_seg_bin_display: RTL and testbench

- Parametrised multi-digit successor to the single-digit BCD-to-7-segment decoder.
- Accepts an unsigned binary value (for example a queue ticket or counter number) through a valid/ready handshake.
- Converts it to BCD with a sequential shift-add-3 (double-dabble) engine, then drives NUM_DIGITS registered 7-segment patterns on the DE10-Lite HEX displays.
- Adds selectable polarity, leading-zero blanking, overflow indication and a display blank control.

---
 rtl/seven_seg_bin_display.sv | 208 ++++++++++++++++++++
 tb/tb_seven_seg_bin_display.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_bin_display.sv
// seven_seg_bin_display: multi-digit binary-to-7-segment display driver.
// A value accepted over a valid/ready handshake is converted to BCD by a
// sequential shift-add-3 (double-dabble) engine, one input bit per cycle, and
// the resulting digits are registered as segment patterns for the HEX displays.
// Supports either segment polarity, leading-zero blanking, an overflow
// indication (all dashes) and a registered display blank control.
module seven_seg_bin_display #(
    parameter int unsigned NUM_DIGITS    = 4,     // 1..6, digit 0 least significant
    parameter int unsigned BIN_WIDTH     = 14,    // 4..20
    parameter bit          ACTIVE_LOW    = 1'b1,  // 1: lit segment driven 0
    parameter bit          BLANK_LEADING = 1'b1   // 1: blank leading zero digits
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    blank,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    overflow,
    output logic                    done
);

    localparam int unsigned BcdWidth = 4 * NUM_DIGITS;
    localparam int unsigned SegWidth = 7 * NUM_DIGITS;
    localparam int unsigned CntWidth = $clog2(BIN_WIDTH);

    // Largest value that fits on the display, 10^NUM_DIGITS - 1.
    function automatic int unsigned calc_max_value();
        int unsigned p;
        p = 1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam int unsigned MaxValue = calc_max_value();

    // Logical segment codes, {a,b,c,d,e,f,g}, lit = 1.
    localparam logic [6:0] SegBlank = 7'b0000000;
    localparam logic [6:0] SegDash  = 7'b0000001;
    localparam logic [6:0] SegZero  = 7'b1111110;

    // Reset shows a single "0" on digit 0, all other digits blank.
    localparam logic [SegWidth-1:0] ResetDigits = SegWidth'(SegZero);

    // Converter states.
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StShift  = 2'd1;
    localparam logic [1:0] StUpdate = 2'd2;

    // BCD nibble to logical segment code; anything above 9 shows blank.
    function automatic logic [6:0] decode_digit(input logic [3:0] nibble);
        logic [6:0] code;
        unique case (nibble)
            4'd0:    code = 7'b1111110;
            4'd1:    code = 7'b0110000;
            4'd2:    code = 7'b1101101;
            4'd3:    code = 7'b1111001;
            4'd4:    code = 7'b0110011;
            4'd5:    code = 7'b1011011;
            4'd6:    code = 7'b1011111;
            4'd7:    code = 7'b1110000;
            4'd8:    code = 7'b1111111;
            4'd9:    code = 7'b1111011;
            default: code = SegBlank;
        endcase
        return code;
    endfunction

    // Converter state.
    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [BcdWidth-1:0]  bcd_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 ovf_pending_q;

    // Display state.
    logic [SegWidth-1:0]  digits_q;
    logic                 overflow_q;
    logic                 done_q;
    logic                 blank_q;

    // Combinational helpers.
    logic                 accept;
    logic                 ovf_detect;
    logic                 last_iter;
    logic [BcdWidth-1:0]  bcd_adj;
    logic [BcdWidth-1:0]  bcd_shift;
    logic [BIN_WIDTH-1:0] bin_shift;
    logic                 unused_shift_out;
    logic [SegWidth-1:0]  seg_new;
    logic [SegWidth-1:0]  seg_shown;
    logic [3:0]           nibble;
    logic                 zero_run;

    assign load_ready = (state_q == StIdle);
    assign accept     = load_valid & load_ready;

    // Compared at 32 bits so no input value can wrap against the limit.
    assign ovf_detect = 32'(bin_in) > MaxValue;

    assign last_iter  = (cnt_q == CntWidth'(BIN_WIDTH - 1));

    // Add-3 correction on every nibble that would reach 10 or more after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // The bit shifted out of the top nibble only matters on overflow, where
    // the BCD result is never shown.
    assign {unused_shift_out, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};

    // Next-state logic: idle until a handshake, BIN_WIDTH shift cycles, one update cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StShift;
            StShift:  if (last_iter) state_d = StUpdate;
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Converter registers: capture on handshake, then one double-dabble step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        bin_q         <= bin_in;
                        bcd_q         <= '0;
                        cnt_q         <= '0;
                        ovf_pending_q <= ovf_detect;
                    end
                end
                StShift: begin
                    bcd_q <= bcd_shift;
                    bin_q <= bin_shift;
                    cnt_q <= cnt_q + CntWidth'(1);
                end
                default: ;
            endcase
        end
    end

    // Segment patterns for the finished conversion, scanning from the most
    // significant digit so leading zeros can be detected in one pass.
    always_comb begin
        seg_new  = '0;
        nibble   = '0;
        zero_run = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            nibble   = bcd_q[4*k +: 4];
            zero_run = zero_run & (nibble == 4'd0);
            if (ovf_pending_q) begin
                seg_new[7*k +: 7] = SegDash;
            end else if (BLANK_LEADING && (k > 0) && zero_run) begin
                seg_new[7*k +: 7] = SegBlank;
            end else begin
                seg_new[7*k +: 7] = decode_digit(nibble);
            end
        end
    end

    // Display registers: load new digits and overflow in UPDATE, done follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q   <= ResetDigits;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == StUpdate);
            if (state_q == StUpdate) begin
                digits_q   <= seg_new;
                overflow_q <= ovf_pending_q;
            end
        end
    end

    // Blank request is registered; latched digits stay intact underneath it.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank;
        end
    end

    assign seg_shown = blank_q ? '0 : digits_q;
    assign seg       = ACTIVE_LOW ? ~seg_shown : seg_shown;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seven_seg_bin_display.sv
// Bench for seven_seg_bin_display: three configurations run side by side
// against a decimal-arithmetic reference model.
//   a: 4 digits, 14-bit input, active-low, leading-zero blanking
//   b: 2 digits,  7-bit input, active-high, leading-zero blanking
//   c: 4 digits, 14-bit input, active-low, all digits shown
module tb_seven_seg_bin_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        blank;
    logic [13:0] bin_ac;
    logic [6:0]  bin_b;

    logic [27:0] seg_a, seg_c;
    logic [13:0] seg_b;
    logic        ready_a, ready_b, ready_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    logic [41:0] exp_seg_a, exp_seg_b, exp_seg_c;
    logic        exp_ovf_a, exp_ovf_b, exp_ovf_c;

    always #5 clk = ~clk;

    seven_seg_bin_display #(
        .NUM_DIGITS(4), .BIN_WIDTH(14), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .bin_in(bin_ac), .load_valid(load_valid),
        .load_ready(ready_a), .blank(blank), .seg(seg_a), .overflow(ovf_a), .done(done_a)
    );

    seven_seg_bin_display #(
        .NUM_DIGITS(2), .BIN_WIDTH(7), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .bin_in(bin_b), .load_valid(load_valid),
        .load_ready(ready_b), .blank(blank), .seg(seg_b), .overflow(ovf_b), .done(done_b)
    );

    seven_seg_bin_display #(
        .NUM_DIGITS(4), .BIN_WIDTH(14), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)
    ) dut_c (
        .clk(clk), .rst(rst), .bin_in(bin_ac), .load_valid(load_valid),
        .load_ready(ready_c), .blank(blank), .seg(seg_c), .overflow(ovf_c), .done(done_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_code(input int unsigned d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    // Physical segment vector the display should show for value v.
    function automatic logic [41:0] model_seg(input int unsigned v, input int n, input bit al,
                                              input bit bl);
        logic [41:0] r;
        logic [6:0]  c;
        int unsigned lim, pw;
        lim = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        r  = '0;
        pw = 1;
        for (int k = 0; k < n; k++) begin
            if (v >= lim)                    c = 7'b0000001;
            else if (bl && k > 0 && v < pw)  c = 7'b0000000;
            else                             c = digit_code((v / pw) % 10);
            if (al) c = ~c;
            r[7*k +: 7] = c;
            pw = pw * 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] model_reset(input int n, input bit al);
        logic [41:0] r;
        logic [6:0]  c;
        r = '0;
        for (int k = 0; k < n; k++) begin
            c = (k == 0) ? 7'b1111110 : 7'b0000000;
            if (al) c = ~c;
            r[7*k +: 7] = c;
        end
        return r;
    endfunction

    function automatic logic [41:0] model_off(input int n, input bit al);
        logic [41:0] r;
        r = '0;
        if (al) begin
            for (int k = 0; k < 7 * n; k++) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Checks for one instance, j edges after the handshake edge.
    task automatic check_phase(input string nm, input int j, input int bw, input logic rdy,
                               input logic dn, input logic [41:0] sg, input logic ov,
                               input logic [41:0] old_sg, input logic [41:0] new_sg,
                               input logic new_ov);
        if (j <= bw) begin
            check({nm, "_ready_busy"}, 64'(rdy), 64'd0);
            check({nm, "_done_early"}, 64'(dn), 64'd0);
            if (j == bw) check({nm, "_seg_held"}, 64'(sg), 64'(old_sg));
        end else if (j == bw + 1) begin
            check({nm, "_done"}, 64'(dn), 64'd1);
            check({nm, "_ready_back"}, 64'(rdy), 64'd1);
            check({nm, "_seg"}, 64'(sg), 64'(new_sg));
            check({nm, "_ovf"}, 64'(ov), 64'(new_ov));
        end else begin
            check({nm, "_done_late"}, 64'(dn), 64'd0);
        end
    endtask

    // One conversion on all three instances; inject pulses load_valid with 99 mid-shift.
    task automatic convert(input int unsigned va, input int unsigned vb, input bit inject);
        logic [41:0] na, nb, nc;
        logic        oa, ob;
        na = model_seg(va, 4, 1'b1, 1'b1);
        nc = model_seg(va, 4, 1'b1, 1'b0);
        nb = model_seg(vb, 2, 1'b0, 1'b1);
        oa = (va > 9999);
        ob = (vb > 99);
        @(negedge clk);
        check("a_ready_start", 64'(ready_a), 64'd1);
        check("b_ready_start", 64'(ready_b), 64'd1);
        check("c_ready_start", 64'(ready_c), 64'd1);
        bin_ac     = 14'(va);
        bin_b      = 7'(vb);
        load_valid = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            check_phase("a", j, 14, ready_a, done_a, 42'(seg_a), ovf_a, exp_seg_a, na, oa);
            check_phase("b", j, 7, ready_b, done_b, 42'(seg_b), ovf_b, exp_seg_b, nb, ob);
            check_phase("c", j, 14, ready_c, done_c, 42'(seg_c), ovf_c, exp_seg_c, nc, oa);
            load_valid = inject && (j == 4);
            if (inject && j == 4) begin
                bin_ac = 14'd99;
                bin_b  = 7'd99;
            end
        end
        exp_seg_a = na; exp_seg_b = nb; exp_seg_c = nc;
        exp_ovf_a = oa; exp_ovf_b = ob; exp_ovf_c = oa;
    endtask

    // Start a conversion, then reset partway through the shift phase.
    task automatic reset_mid(input int unsigned va, input int unsigned vb);
        @(negedge clk);
        bin_ac     = 14'(va);
        bin_b      = 7'(vb);
        load_valid = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            load_valid = 1'b0;
            check("a_done_after_rst", 64'(done_a), 64'd0);
            check("b_done_after_rst", 64'(done_b), 64'd0);
            check("c_done_after_rst", 64'(done_c), 64'd0);
            if (j == 7) begin
                check("a_seg_rst", 64'(seg_a), 64'(model_reset(4, 1'b1)));
                check("b_seg_rst", 64'(seg_b), 64'(model_reset(2, 1'b0)));
                check("c_seg_rst", 64'(seg_c), 64'(model_reset(4, 1'b1)));
                check("a_ovf_rst", 64'(ovf_a), 64'd0);
                check("b_ovf_rst", 64'(ovf_b), 64'd0);
                check("a_ready_rst", 64'(ready_a), 64'd1);
            end
            rst = (j == 6);
        end
        exp_seg_a = model_reset(4, 1'b1);
        exp_seg_b = model_reset(2, 1'b0);
        exp_seg_c = model_reset(4, 1'b1);
        exp_ovf_a = 1'b0; exp_ovf_b = 1'b0; exp_ovf_c = 1'b0;
    endtask

    task automatic blank_test();
        @(negedge clk);
        check("a_seg_preblank", 64'(seg_a), 64'(exp_seg_a));
        blank = 1'b1;
        @(negedge clk);
        check("a_seg_blank", 64'(seg_a), 64'(model_off(4, 1'b1)));
        check("b_seg_blank", 64'(seg_b), 64'(model_off(2, 1'b0)));
        check("c_seg_blank", 64'(seg_c), 64'(model_off(4, 1'b1)));
        check("a_ovf_blank", 64'(ovf_a), 64'(exp_ovf_a));
        blank = 1'b0;
        @(negedge clk);
        check("a_seg_unblank", 64'(seg_a), 64'(exp_seg_a));
        check("b_seg_unblank", 64'(seg_b), 64'(exp_seg_b));
        check("c_seg_unblank", 64'(seg_c), 64'(exp_seg_c));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned va, vb;
        rst        = 1'b1;
        load_valid = 1'b0;
        blank      = 1'b0;
        bin_ac     = '0;
        bin_b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_seg_reset", 64'(seg_a), 64'(model_reset(4, 1'b1)));
        check("b_seg_reset", 64'(seg_b), 64'(model_reset(2, 1'b0)));
        check("c_seg_reset", 64'(seg_c), 64'(model_reset(4, 1'b1)));
        check("a_ready_reset", 64'(ready_a), 64'd1);
        check("a_ovf_reset", 64'(ovf_a), 64'd0);
        check("a_done_reset", 64'(done_a), 64'd0);
        check("b_done_reset", 64'(done_b), 64'd0);
        rst = 1'b0;
        exp_seg_a = model_reset(4, 1'b1);
        exp_seg_b = model_reset(2, 1'b0);
        exp_seg_c = model_reset(4, 1'b1);
        exp_ovf_a = 1'b0; exp_ovf_b = 1'b0; exp_ovf_c = 1'b0;

        convert(1234, 42, 1'b0);
        convert(7, 7, 1'b0);
        convert(10000, 100, 1'b0);
        convert(42, 42, 1'b0);
        convert(5, 5, 1'b1);
        convert(0, 0, 1'b0);
        blank_test();
        convert(16383, 127, 1'b0);
        reset_mid(3333, 77);
        convert(9999, 99, 1'b0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       va = $urandom_range(0, 9);
                1:       va = $urandom_range(0, 9999);
                2:       va = $urandom_range(10000, 16383);
                default: va = $urandom_range(0, 999);
            endcase
            vb = $urandom_range(0, 127);
            convert(va, vb, $urandom_range(0, 3) == 0);
        end
        blank_test();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
